// File: rtl/approx_mult_engine.sv
// Sequential approximate multiplier: reads eight operand pairs from the input memory,
// multiplies their leading-one windows by shift-and-add and writes shifted products out.
module approx_mult_engine #(
    parameter int num_of_words    = 8,
    parameter int bits_of_words   = 32,
    parameter int address_bits    = 3,
    parameter int in_bits         = 16,
    parameter int in_address_bits = 4,
    parameter int window_bits     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic [in_address_bits-1:0] in_address,
    input  logic [in_bits-1:0]         in_word,
    output logic [address_bits-1:0]    address,
    output logic                       write_enable,
    output logic [bits_of_words-1:0]   word,
    output logic                       busy,
    output logic                       done
);

    localparam int SW   = $clog2(in_bits - window_bits + 1);
    localparam int SSW  = SW + 1;
    localparam int STW  = $clog2(window_bits);
    localparam int PW   = 2 * window_bits;

    typedef enum logic [2:0] {
        IDLE, RD_A, RD_B, LOAD, MULT, WR, DONE
    } state_t;

    state_t                  state, next_state;
    logic [address_bits-1:0] idx;
    logic [in_bits-1:0]      a_reg;
    logic [PW-1:0]           mcand;
    logic [PW-1:0]           acc;
    logic [PW-1:0]           acc_next;
    logic [window_bits-1:0]  mplier;
    logic [STW-1:0]          step;
    logic [SSW-1:0]          shift_sum;
    logic [SW+window_bits-1:0] norm_a, norm_b;

    // Returns {shift, window}: the 8 bits starting at the leading one, lower bits truncated.
    function automatic logic [SW+window_bits-1:0] normalize(input logic [in_bits-1:0] x);
        logic [SW-1:0] sh;
        sh = '0;
        for (int p = window_bits; p < in_bits; p++) begin
            if (x[p]) sh = SW'(p - window_bits + 1);
        end
        return {sh, window_bits'(x >> sh)};
    endfunction

    assign norm_a   = normalize(a_reg);
    assign norm_b   = normalize(in_word);
    assign acc_next = acc + (mplier[0] ? mcand : '0);

    assign in_address = {idx, state == RD_B};
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = RD_A;
            RD_A: next_state = RD_B;
            RD_B: next_state = LOAD;
            LOAD: next_state = MULT;
            MULT: if (step == STW'(window_bits - 1)) next_state = WR;
            WR:   next_state = (idx == address_bits'(num_of_words - 1)) ? DONE : RD_A;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx          <= '0;
            a_reg        <= '0;
            mcand        <= '0;
            acc          <= '0;
            mplier       <= '0;
            step         <= '0;
            shift_sum    <= '0;
            address      <= '0;
            word         <= '0;
            write_enable <= 1'b0;
        end else begin
            write_enable <= (next_state == WR);
            case (state)
                IDLE: if (start) idx <= '0;
                RD_B: a_reg <= in_word;
                LOAD: begin
                    mcand     <= PW'(norm_a[window_bits-1:0]);
                    mplier    <= norm_b[window_bits-1:0];
                    shift_sum <= SSW'(norm_a[SW+window_bits-1:window_bits])
                               + SSW'(norm_b[SW+window_bits-1:window_bits]);
                    acc       <= '0;
                    step      <= '0;
                end
                MULT: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    step   <= step + 1'b1;
                    // Output registers load on the final step so they are valid throughout WR.
                    if (step == STW'(window_bits - 1)) begin
                        word    <= bits_of_words'(acc_next) << shift_sum;
                        address <= idx;
                    end
                end
                WR: if (idx != address_bits'(num_of_words - 1)) idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_approx_mult_engine.sv
// Bench for approx_mult_engine: input/output memory models, write scoreboard, cycle-accurate schedule.
module tb_approx_mult_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  in_address;
    logic [15:0] in_word;
    logic [2:0]  address;
    logic        write_enable;
    logic [31:0] word;
    logic        busy;
    logic        done;

    logic [15:0] in_mem [16];
    logic [31:0] out_mem [8];

    logic [31:0] exp_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_cyc_q[$];
    logic [31:0] exp_done_q[$];

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;
    int t0       = 0;

    approx_mult_engine dut (
        .clk(clk), .rst(rst), .start(start),
        .in_address(in_address), .in_word(in_word),
        .address(address), .write_enable(write_enable), .word(word),
        .busy(busy), .done(done)
    );

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(posedge clk) in_word <= in_mem[in_address];
    always @(posedge clk) if (write_enable) out_mem[address] <= word;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
        int sa = 0;
        int sb = 0;
        logic [31:0] wa, wb;
        while ((a >> sa) > 16'd255) sa++;
        while ((b >> sb) > 16'd255) sb++;
        wa = 32'(a >> sa);
        wb = 32'(b >> sb);
        return (wa * wb) << (sa + sb);
    endfunction

    // scoreboard: one expected entry per write and per done pulse
    always @(negedge clk) begin
        if (!rst && write_enable) begin
            if (exp_q.size() == 0) begin
                check("extra_write", {29'b0, address}, 32'hFFFF_FFFF);
            end else begin
                check("wr_word", word, exp_q.pop_front());
                check("wr_addr", {29'b0, address}, exp_addr_q.pop_front());
                check("wr_cycle", 32'(edge_cnt - t0 + 1), exp_cyc_q.pop_front());
            end
        end
        if (!rst && done) begin
            if (exp_done_q.size() == 0) check("extra_done", 32'(edge_cnt - t0 + 1), 32'hFFFF_FFFF);
            else check("done_cycle", 32'(edge_cnt - t0 + 1), exp_done_q.pop_front());
        end
    end

    task automatic push_run(input int base, input int n_writes, input bit with_done);
        for (int k = 0; k < n_writes; k++) begin
            exp_q.push_back(model(in_mem[2*k], in_mem[2*k+1]));
            exp_addr_q.push_back(32'(k));
            exp_cyc_q.push_back(32'(base + 12 + 12*k));
        end
        if (with_done) exp_done_q.push_back(32'(base + 97));
    endtask

    task automatic fill_random();
        for (int j = 0; j < 16; j++)
            in_mem[j] = (j % 3 == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom_range(0, 65535));
    endtask

    // start sampled at the next rising edge, which becomes edge 0 of the run
    task automatic launch(input bit hold);
        start = 1'b1;
        @(posedge clk);
        #1;
        t0 = edge_cnt;
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_cycle(input int c);
        for (int n = 0; n < 400 && (edge_cnt - t0 + 1) < c; n++) @(negedge clk);
        check("wait_cycle_reached", 32'(edge_cnt - t0 + 1), 32'(c));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_we"},    {31'b0, write_enable}, 32'd0);
        check({tag, "_busy"},  {31'b0, busy}, 32'd0);
        check({tag, "_done"},  {31'b0, done}, 32'd0);
        check({tag, "_addr"},  {29'b0, address}, 32'd0);
        check({tag, "_word"},  word, 32'd0);
        check({tag, "_inadr"}, {28'b0, in_address}, 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        for (int j = 0; j < 8; j++) out_mem[j] = 32'hDEAD_BEEF;
        fill_random();
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // run 1: directed operand pairs plus a start pulse while busy
        in_mem[0]  = 16'h0003; in_mem[1]  = 16'h0005;
        in_mem[2]  = 16'hFFFF; in_mem[3]  = 16'hFFFF;
        in_mem[4]  = 16'h1234; in_mem[5]  = 16'h0100;
        in_mem[10] = 16'h0000; in_mem[11] = 16'hFFFF;
        launch(1'b0);
        push_run(0, 8, 1'b1);
        wait_cycle(2);
        check("busy_cycle2", {31'b0, busy}, 32'd1);
        wait_cycle(40);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cycle(97);
        check("busy_cycle97", {31'b0, busy}, 32'd1);
        wait_cycle(98);
        check("busy_cycle98", {31'b0, busy}, 32'd0);
        check("done_cycle98", {31'b0, done}, 32'd0);
        wait_cycle(110);
        check("run1_busy_after_ignored_start", {31'b0, busy}, 32'd0);
        check("run1_pending_writes", 32'(exp_q.size()), 32'd0);
        check("run1_pending_done", 32'(exp_done_q.size()), 32'd0);
        check("mem0_small", out_mem[0], 32'h0000_000F);
        check("mem1_saturated", out_mem[1], 32'hFE01_0000);
        check("mem2_truncated", out_mem[2], 32'h0012_2000);
        check("mem5_zero", out_mem[5], 32'h0000_0000);

        // run 2 with start held: run 3 follows from the IDLE cycle, then is aborted by rst
        fill_random();
        launch(1'b1);
        push_run(0, 8, 1'b1);
        push_run(98, 2, 1'b0);
        wait_cycle(98);
        check("held_idle_busy", {31'b0, busy}, 32'd0);
        wait_cycle(99);
        check("restart_busy", {31'b0, busy}, 32'd1);
        wait_cycle(100);
        start = 1'b0;
        wait_cycle(128);
        rst = 1'b1;
        #1;
        check_idle_outputs("abort");
        check("abort_pending_writes", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        check("abort_mem1_kept", out_mem[1], model(in_mem[2], in_mem[3]));
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("after_abort_idle", {31'b0, busy}, 32'd0);

        // run 4: fresh start from pair 0
        fill_random();
        launch(1'b0);
        push_run(0, 8, 1'b1);
        wait_cycle(105);
        check("run4_pending_writes", 32'(exp_q.size()), 32'd0);
        check("run4_pending_done", 32'(exp_done_q.size()), 32'd0);
        for (int k = 0; k < 8; k++)
            check($sformatf("run4_mem%0d", k), out_mem[k], model(in_mem[2*k], in_mem[2*k+1]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
